// File: rtl/dmem_responder.sv
// Single-port data memory responder with a fixed wait-state count per request.
// Optional macro DMEM_RANGE_CHECK_EN flags out-of-range addresses as errors.
module dmem_responder #(
    parameter int ADDR_WORDS  = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(ADDR_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          oor_q, oor_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic          oor_in;

    logic [31:0] mem [ADDR_WORDS];

`ifdef DMEM_RANGE_CHECK_EN
    assign oor_in = |req_addr[31:AW+2];
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];
`else
    // Upper address bits alias into the array.
    assign oor_in = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    idx_d   = req_addr[AW+1:2];
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    oor_d   = oor_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state; read data is the pre-write word.
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        resp_err_d   = resp_valid_d && oor_d;
        resp_rdata_d = (resp_valid_d && !oor_d) ? mem[idx_d] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            idx_q        <= '0;
            we_q         <= 4'd0;
            wdata_q      <= 32'd0;
            oor_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            oor_q        <= oor_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Store commits on the edge leaving RESP; reset there aborts it.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_RESP && !oor_q) begin
            for (int b = 0; b < 4; b++) begin
                if (we_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WORDS, default 1024, meaning memory depth in 32-bit words, a power of two, 4..65536.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each response, 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit, meaning the CPU memory stage presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit, meaning the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_addr, input, 32 bits, meaning the byte address of the request.
REQ-008 The block SHALL have port req_we, input, 4 bits, meaning per-byte write enables, with 4'b0000 meaning a read.
REQ-009 The block SHALL have port req_wdata, input, 32 bits, meaning the store data, with byte i on bits 8i+7:8i.
REQ-010 The block SHALL have port resp_valid, output, 1 bit, meaning a single-cycle response strobe.
REQ-011 The block SHALL have port resp_rdata, output, 32 bits, meaning the response word, valid only while resp_valid=1.
REQ-012 The block SHALL have port resp_err, output, 1 bit, meaning an access error, valid only while resp_valid=1.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 In IDLE, req_ready SHALL be 1; in WAIT and RESP it SHALL be 0.
REQ-015 A request SHALL be accepted on an edge with req_valid=1 and req_ready=1; this latches addr, we and wdata, and all later input changes are ignored until the next IDLE.
REQ-016 On accept, the FSM SHALL go to RESP if WAIT_CYCLES=0; otherwise it SHALL go to WAIT with the counter loaded with WAIT_CYCLES-1.
REQ-017 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter equals 0.
REQ-018 In RESP, resp_valid SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-019 resp_valid SHALL assert WAIT_CYCLES+1 cycles after the accept edge; sustained throughput SHALL be one request per WAIT_CYCLES+2 cycles.
REQ-020 The word index SHALL be latched addr[log2(ADDR_WORDS)+1:2]; addr[1:0] SHALL be ignored, since byte selection is by req_we.
REQ-021 For reads, resp_rdata SHALL be the stored word at the index; for writes, resp_rdata SHALL be the pre-write word.
REQ-022 Writes SHALL update only the enabled bytes, committed on the edge leaving RESP; a request accepted afterwards SHALL observe the new data.
REQ-023 resp_rdata SHALL be 0 whenever resp_valid=0.

Reset
REQ-024 While reset=1 at an edge, the FSM SHALL go to IDLE and the counter to 0; outputs SHALL then be req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-025 Reset in WAIT or RESP SHALL abort the request with no response and no write commit; a request presented during reset SHALL NOT be accepted.
REQ-026 Memory array contents SHALL NOT be affected by reset.

Configuration
REQ-027 With macro DMEM_RANGE_CHECK_EN defined, a latched address at or above 4*ADDR_WORDS SHALL produce resp_err=1 with resp_rdata=0 and a suppressed write; timing SHALL be unchanged.
REQ-028 Without DMEM_RANGE_CHECK_EN, resp_err SHALL be constant 0 and upper address bits SHALL alias (wrap-around) into the array.

Verification (ADDR_WORDS=1024, WAIT_CYCLES=2)
REQ-029 Write 0xDEADBEEF to 0x10 with we=4'hF, then read 0x10 -> response to the read has resp_rdata=0xDEADBEEF, and resp_valid asserts exactly 3 cycles after each accept.
REQ-030 Read 0x10 after the REQ-029 write, then write 0x000000AA with we=4'b0001 -> the write response returns 0xDEADBEEF; a subsequent read of 0x10 returns 0xDEADBEAA.
REQ-031 Hold req_valid=1 continuously with changing addresses -> req_ready=0 during WAIT/RESP, one accept every 4 cycles, only accept-cycle values used.
REQ-032 Assert reset during WAIT of a write to 0x20 -> no resp_valid, and a read of 0x20 after reset returns the prior contents.
REQ-033 Write 0x12345678 to 0x1000 -> with macro: resp_err=1, and a read of 0x0 remains unchanged; without macro: resp_err=0, and a read of 0x0 returns 0x12345678.
REQ-034 With WAIT_CYCLES=0, back-to-back reads -> resp_valid 1 cycle after accept, one accept every 2 cycles.
